// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: DEPTH-entry instruction prefetch queue; the head is the current IR, split into opcode/operand.
// Latency: a word pushed at edge N is on the head after edge N; a pop at edge N exposes the next entry after edge N; no bypass.
// Backpressure: in_ready drops when full, during flush or during reset; a same-cycle pop never frees a slot for a push.
// Optional feature macro: IR_PARITY_EN adds in_par (even parity of in_instr, stored per entry) and par_err on the head.
module ir_prefetch_queue #(
   parameter int IW    = 16,
   parameter int OPW   = 6,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [IW-1:0]             in_instr,
   output logic                      in_ready,
   input  logic                      advance,
   input  logic                      flush,
   output logic                      ir_valid,
   output logic [OPW-1:0]            opcode,
   output logic [IW-OPW-1:0]         operand,
   output logic [$clog2(DEPTH):0]    count
`ifdef IR_PARITY_EN
   ,
   input  logic                      in_par,
   output logic                      par_err
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Instruction storage; contents are don't-care until written, so no reset.
   logic [IW-1:0] mem [DEPTH];
`ifdef IR_PARITY_EN
   logic          par_mem [DEPTH];
`endif

   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;
   logic [IW-1:0] head_word;

   // Accept only when there is a free slot right now; flush and reset both close the input.
   always_comb begin
      in_ready = !rst && !flush && (cnt < FULL_CNT);
      push     = in_valid && in_ready;
      ir_valid = (cnt != '0);
      pop      = advance && ir_valid && !flush;
   end

   // Pointer and occupancy bookkeeping; reset wins over flush, flush wins over push/pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) begin
            wp <= wp + AW'(1);
         end
         if (pop) begin
            rp <= rp + AW'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + CW'(1);
         end else if (pop && !push) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   // Write the accepted word (and its parity bit) into the tail slot.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= in_instr;
`ifdef IR_PARITY_EN
         par_mem[wp] <= in_par;
`endif
      end
   end

   // Present the head split into fields, forced to zero while the queue is empty.
   always_comb begin
      head_word = mem[rp];
      opcode    = '0;
      operand   = '0;
      if (ir_valid) begin
         opcode  = head_word[IW-1:IW-OPW];
         operand = head_word[IW-OPW-1:0];
      end
   end

`ifdef IR_PARITY_EN
   // Even parity over word plus stored bit must be zero; anything else flags the head.
   always_comb begin
      par_err = ir_valid && ((^head_word) ^ par_mem[rp]);
   end
`endif

   assign count = cnt;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// tb_ir_prefetch_queue: scoreboard bench for ir_prefetch_queue.
// Expected words are queued when accepted and compared against the head each cycle; popped on retire.
// Under IR_PARITY_EN the stored parity bit travels with each scoreboard entry.
module tb_ir_prefetch_queue;

   localparam int IW    = 16;
   localparam int OPW   = 6;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic [IW-1:0]     in_instr;
   logic              in_ready;
   logic              advance;
   logic              flush;
   logic              ir_valid;
   logic [OPW-1:0]    opcode;
   logic [IW-OPW-1:0] operand;
   logic [CW-1:0]     count;
   logic              in_par;
`ifdef IR_PARITY_EN
   logic              par_err;
`endif

   int n_chk;
   int n_err;

   // Scoreboard entries are {parity, word}.
   logic [IW:0] sb [$];

   ir_prefetch_queue #(.IW(IW), .OPW(OPW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_instr (in_instr),
      .in_ready (in_ready),
      .advance  (advance),
      .flush    (flush),
      .ir_valid (ir_valid),
      .opcode   (opcode),
      .operand  (operand),
      .count    (count)
`ifdef IR_PARITY_EN
      ,
      .in_par   (in_par),
      .par_err  (par_err)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare the head, occupancy and flags against the scoreboard.
   task automatic check_head(input string tag);
      logic [IW:0] e;
      chk({tag, ".count"}, 32'(count), 32'(sb.size()));
      chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         e = sb[0];
         chk({tag, ".opcode"}, 32'(opcode), 32'(e[IW-1:IW-OPW]));
         chk({tag, ".operand"}, 32'(operand), 32'(e[IW-OPW-1:0]));
      end else begin
         chk({tag, ".opcode0"}, 32'(opcode), 32'd0);
         chk({tag, ".operand0"}, 32'(operand), 32'd0);
      end
`ifdef IR_PARITY_EN
      chk({tag, ".par_err"}, 32'(par_err), 32'((sb.size() != 0) && (^sb[0])));
`endif
   endtask

   // One clock of stimulus: drive, check in_ready, update the model, clock, check the head.
   task automatic step(input string tag, input logic v, input logic [IW-1:0] w,
                       input logic adv, input logic fl, input logic p);
      logic exp_rdy;
      logic do_push;
      logic do_pop;
      in_valid = v;
      in_instr = w;
      advance  = adv;
      flush    = fl;
      in_par   = p;
      #1;
      exp_rdy = !fl && (sb.size() < DEPTH);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
      do_push = v && exp_rdy;
      do_pop  = adv && (sb.size() != 0) && !fl;
      if (fl) begin
         sb.delete();
      end else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) sb.push_back({p, w});
      end
      @(posedge clk);
      #1;
      check_head(tag);
   endtask

   task automatic push_w(input string tag, input logic [IW-1:0] w);
      step(tag, 1'b1, w, 1'b0, 1'b0, ^w);
   endtask

   task automatic pop_w(input string tag);
      step(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_instr = 16'hFFFF;
      in_par   = 1'b0;
      advance  = 1'b1;
      flush    = 1'b0;
      #1;
      chk({tag, ".rdy_in_rst"}, 32'(in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      sb.delete();
      rst      = 1'b0;
      in_valid = 1'b0;
      advance  = 1'b0;
      #1;
      check_head(tag);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      n_chk    = 0;
      n_err    = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_instr = '0;
      in_par   = 1'b0;
      advance  = 1'b0;
      flush    = 1'b0;
      @(posedge clk);
      #1;
      do_reset("reset");

      // Single push with explicit field constants.
      push_w("single", 16'hA5C3);
      chk("single.opc_const", 32'(opcode), 32'(6'b101001));
      chk("single.opr_const", 32'(operand), 32'h1C3);
      pop_w("single_pop");

      // Fill, overflow attempt, drain, then refill across the pointer wrap.
      for (int i = 1; i <= 4; i++) push_w("fill", IW'(i));
      chk("fill.count4", 32'(count), 32'd4);
      push_w("overflow", 16'h0009);
      step("full_pushpop", 1'b1, 16'h000A, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) pop_w("drain");
      for (int i = 5; i <= 8; i++) push_w("wrap", IW'(i));
      for (int i = 0; i < 4; i++) pop_w("wrap_drain");

      // Simultaneous push and pop at count=2.
      push_w("pp_a", 16'h1111);
      push_w("pp_b", 16'h2222);
      step("pp", 1'b1, 16'h3333, 1'b1, 1'b0, ^16'h3333);
      chk("pp.count2", 32'(count), 32'd2);
      chk("pp.head_b", 32'(operand), 32'(10'h222));
      pop_w("pp_pop1");
      pop_w("pp_pop2");

      // Flush at count=3 with in_valid and advance asserted.
      push_w("fl_a", 16'h4444);
      push_w("fl_b", 16'h5555);
      push_w("fl_c", 16'h6666);
      step("flush", 1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
      push_w("post_flush", 16'h7777);
      pop_w("post_flush_pop");

      // Advance while empty, then a clean push.
      for (int i = 0; i < 3; i++) pop_w("empty_adv");
      push_w("after_empty", 16'hBEEF);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 200; i++) begin
         logic [IW-1:0] w;
         w = IW'($urandom);
         step("rand", 1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 19) == 0), ^w);
      end

      // Reset mid-operation discards entries.
      push_w("mid_a", 16'h0F0F);
      push_w("mid_b", 16'hF0F0);
      do_reset("mid_reset");
      push_w("post_reset", 16'h1234);
      pop_w("post_reset_pop");

`ifdef IR_PARITY_EN
      step("par_bad", 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
      chk("par_bad.const", 32'(par_err), 32'd1);
      pop_w("par_bad_pop");
      step("par_good", 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
      chk("par_good.const", 32'(par_err), 32'd0);
      pop_w("par_good_pop");
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
Parametrised instruction register with a DEPTH-entry prefetch queue in front of the decoder. Fetched words are pushed in with a valid/ready handshake. The queue head is the current instruction, presented split into opcode and operand fields. The decoder retires the head with `advance`; `flush` empties the queue on branches and jumps.

Parameters:
- IW, 16, instruction word width in bits (IW > OPW).
- OPW, 6, opcode field width; the opcode is the top OPW bits of the word.
- DEPTH, 4, queue entries; a power of 2, at least 2.

Ports:
- clk  input  1  clock; every register updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  fetch side has a word on in_instr.
- in_instr  input  IW  fetched instruction word.
- in_ready  output  1  queue can accept a word this cycle.
- advance  input  1  decoder retires the current head.
- flush  input  1  discard all queued instructions.
- ir_valid  output  1  head entry holds a valid instruction.
- opcode  output  OPW  head[IW-1:IW-OPW]; 0 when ir_valid=0.
- operand  output  IW-OPW  head[IW-OPW-1:0]; 0 when ir_valid=0.
- count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage: circular buffer with write pointer wp, read pointer rp (each $clog2(DEPTH) bits, wrap modulo DEPTH) and occupancy count.
- Reset (rst=1 at a clk edge): wp=0, rp=0, count=0. After that edge: ir_valid=0, opcode=0, operand=0, in_ready=1. Storage contents need not be cleared.
- Reset overrides flush, push and pop in the same cycle.
- Reset mid-operation discards all entries.
- in_ready = !rst && !flush && (count < DEPTH). It is combinational from registered count and the two inputs.
- push = in_valid && in_ready. Writes in_instr to mem[wp]; wp increments.
- pop = advance && ir_valid && !flush. rp increments.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full (count=DEPTH): in_ready=0, no push. A pop in the same cycle does not enable a push; there is no same-cycle bypass.
- Empty (count=0): advance is ignored and count does not underflow. There is no input-to-output bypass.
- ir_valid = (count != 0). opcode and operand are combinational from mem[rp], gated to 0 when empty.
- Latency:
  - A word pushed into an empty queue at edge N appears on opcode/operand with ir_valid=1 after edge N.
  - A pop at edge N exposes the next entry after edge N.
- Flush (flush=1 at an edge, rst=0): wp=0, rp=0, count=0. A concurrent in_valid word is dropped (in_ready=0 that cycle) and a concurrent advance has no effect. The queue is empty after the edge.
- Pointer wrap: after DEPTH pushes, wp returns to 0. FIFO ordering holds across wrap.
- The in_valid/in_instr stability contract is on the fetch side; the queue samples them only when in_ready=1.

Optional Feature:
- Macro: IR_PARITY_EN.
- Defined:
  - Input in_par (1 bit) is added; it is the even-parity bit of in_instr and is stored per entry.
  - Output par_err (1 bit) is added: combinational, 1 when ir_valid=1 and the XOR of the stored head word and its stored parity bit is 1.
  - par_err is 0 when the queue is empty and after reset.
  - Queue behaviour is otherwise unchanged; the bad entry is still retired normally.
- Undefined: no in_par/par_err ports and no parity storage.

Test Plan:
- Reset: hold rst=1 for 2 edges with in_valid=1, in_instr=16'hFFFF -> count=0, ir_valid=0, opcode=0, operand=0, in_ready=1 after the edge where rst is deasserted.
- Single push: push 16'hA5C3 into an empty queue -> after that edge ir_valid=1, opcode=6'b101001, operand=10'h1C3, count=1.
- Fill and wrap: push 0x0001..0x0004 with advance=0 -> count=4, in_ready=0. A fifth in_valid is not accepted. Then advance four times and push 0x0005..0x0008 -> heads read 1,2,3,4 then 5..8 in order.
- Simultaneous push/pop at count=2 -> count stays 2, the head becomes the second entry, and the new word lands at the tail.
- Flush with in_valid=1 and advance=1 at count=3 -> count=0, ir_valid=0 after the edge. in_ready=0 during the flush cycle. The dropped word never appears.
- Advance when empty: assert advance for 3 cycles with count=0 -> count stays 0, and a later push appears correctly. With IR_PARITY_EN, push 16'h0001 with in_par=0 -> par_err=1; with in_par=1 -> par_err=0.
